// File: rtl/eye_to_pixel_dir.sv
// Pipelined eye-to-pixel ray direction generator: (x, y) pixel -> un-normalized
// IEEE-754 single-precision direction vector, three-cycle latency, one result per clock.
module eye_to_pixel_dir #(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720,
    parameter int unsigned FOCAL  = 1000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    output logic [31:0] dir_x,
    output logic [31:0] dir_y,
    output logic [31:0] dir_z,
    output logic        dir_valid
);

    localparam int unsigned XW   = 11;
    localparam int unsigned YW   = 10;
    localparam int unsigned DW   = 13;
    localparam int unsigned CW   = 25;
    localparam int unsigned FW   = 32;
    localparam int unsigned LATW = 3;

    // Exact integer -> single conversion; every magnitude handled here is below 2^24.
    function automatic logic [FW-1:0] f_int_to_float(input logic [CW-1:0] v);
        logic [CW-1:0] mag;
        logic [4:0]    pos;
        logic [23:0]   shifted;
        logic [FW-1:0] res;
        mag     = v[CW-1] ? CW'(-v) : v;
        pos     = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (mag[i]) pos = 5'(i);
        end
        shifted = mag[23:0] << (5'd23 - pos);
        if (mag == '0) res = '0;
        else           res = {v[CW-1], 8'(127 + 32'(pos)), shifted[22:0]};
        return res;
    endfunction

    localparam logic [DW-1:0] HALF_W   = DW'(WIDTH / 2);
    localparam logic [DW-1:0] HALF_H   = DW'(HEIGHT / 2);
    localparam logic [CW-1:0] FOCAL_I  = CW'(FOCAL);
    localparam logic [FW-1:0] DZ_FLOAT = f_int_to_float(FOCAL_I);

    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic signed [DW-1:0] r_dx;
    logic signed [DW-1:0] r_dy;
    logic [LATW-1:0]      r_vld;

    logic [CW-1:0] w_dx_ext;
    logic [CW-1:0] w_dy_ext;
    logic [FW-1:0] w_fx;
    logic [FW-1:0] w_fy;

    always_comb begin
        w_dx_ext = {{(CW-DW){r_dx[DW-1]}}, r_dx};
        w_dy_ext = {{(CW-DW){r_dy[DW-1]}}, r_dy};
        w_fx     = f_int_to_float(w_dx_ext);
        w_fy     = f_int_to_float(w_dy_ext);
    end

    // Stage 1: sample pixel coordinate
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= x_in;
            r_y <= y_in;
        end
    end

    // Stage 2: signed screen-centred offsets
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_dx <= '0;
            r_dy <= '0;
        end else begin
            r_dx <= $signed({2'b00, r_x} - HALF_W);
            r_dy <= $signed(HALF_H - {3'b000, r_y});
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_vld <= '0;
        else        r_vld <= {r_vld[LATW-2:0], 1'b1};
    end

    // Stage 3: float outputs; held at zero until the pipeline has refilled
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dir_x     <= '0;
            dir_y     <= '0;
            dir_z     <= '0;
            dir_valid <= 1'b0;
        end else begin
            dir_x     <= r_vld[LATW-2] ? w_fx : '0;
            dir_y     <= r_vld[LATW-2] ? w_fy : '0;
            dir_z     <= r_vld[LATW-2] ? DZ_FLOAT : '0;
            dir_valid <= r_vld[LATW-2];
        end
    end

endmodule

// File: tb/tb_eye_to_pixel_dir.sv
// Randomized and directed checks of eye_to_pixel_dir against a real-arithmetic
// reference model, including reset behaviour and three-cycle latency.
module tb_eye_to_pixel_dir;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] x_in   = '0;
    logic [9:0]  y_in   = '0;
    logic [31:0] dir_x;
    logic [31:0] dir_y;
    logic [31:0] dir_z;
    logic        dir_valid;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges  = 0;
    logic [10:0] hx[$];
    logic [9:0]  hy[$];

    eye_to_pixel_dir dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .dir_z     (dir_z),
        .dir_valid (dir_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Exact integer to single via the double-precision bit pattern.
    function automatic logic [31:0] ref_float(input int v);
        logic [63:0] b;
        if (v == 0) return 32'h0;
        b = $realtobits(real'(v));
        return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    endfunction

    // Drive one pixel, let one rising edge pass, then check against the model.
    task automatic step(input logic [10:0] x, input logic [9:0] y);
        logic [10:0] sx;
        logic [9:0]  sy;
        x_in = x;
        y_in = y;
        hx.push_back(x);
        hy.push_back(y);
        @(negedge clk_in);
        n_edges++;
        if (n_edges >= 3) begin
            sx = hx.pop_front();
            sy = hy.pop_front();
            check("valid", 32'(dir_valid), 32'd1);
            check("dir_x", dir_x, ref_float(int'(sx) - 640));
            check("dir_y", dir_y, ref_float(360 - int'(sy)));
            check("dir_z", dir_z, ref_float(1000));
        end else begin
            check("fill_valid", 32'(dir_valid), 32'd0);
            check("fill_dir_x", dir_x, 32'h0);
            check("fill_dir_y", dir_y, 32'h0);
            check("fill_dir_z", dir_z, 32'h0);
        end
    endtask

    task automatic release_reset();
        @(negedge clk_in);
        rst_in  = 1'b0;
        n_edges = 0;
        hx.delete();
        hy.delete();
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_valid"}, 32'(dir_valid), 32'd0);
        check({tag, "_x"}, dir_x, 32'h0);
        check({tag, "_y"}, dir_y, 32'h0);
        check({tag, "_z"}, dir_z, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check_in_reset("rst");
        release_reset();

        repeat (6) step(11'd5, 10'd50);
        check("hold_x", dir_x, 32'hC41EC000);
        check("hold_y", dir_y, 32'h439B0000);
        check("hold_z", dir_z, 32'h447A0000);

        repeat (4) step(11'd640, 10'd360);
        check("ctr_x", dir_x, 32'h00000000);
        check("ctr_y", dir_y, 32'h00000000);

        repeat (4) step(11'd2047, 10'd1023);
        check("ext_x", dir_x, 32'h44AFE000);
        check("ext_y", dir_y, 32'hC425C000);

        // Asynchronous reset mid-stream, checked before any clock edge.
        step(11'd100, 10'd200);
        #2 rst_in = 1'b1;
        #1 check_in_reset("async");
        repeat (2) @(negedge clk_in);
        check_in_reset("held");
        release_reset();

        for (int i = 0; i < 1280; i++) step(11'(i), 10'd123);

        for (int i = 0; i < 10000; i++)
            step(11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
